fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
Controller for configurable_fir. Stores several coefficient banks locally and reprograms the FIR on request. Reprogramming drains any in-flight sample, pulses the FIR enable low, then streams all M*N taps over the FIR tap handshake. Upstream samples pass through to the FIR only while a bank is loaded and the FIR is running.

Parameters:
G_NUM_STAGES_LOG2, 2, log2 of FIR stage count N; must match the FIR instance
G_STAGE_DEPTH_LOG2, 2, log2 of FIR stage depth M; must match the FIR instance
G_TAP_WIDTH, 16, coefficient width
G_DATA_WIDTH, 16, sample width
G_NUM_BANKS_LOG2, 2, log2 of stored coefficient banks (NB)

Ports:
clk  in  1  clock, single domain
reset  in  1  synchronous, active-high
wr_bank  in  G_NUM_BANKS_LOG2  host coefficient write bank
wr_addr  in  NL+ML  tap index (NL = G_NUM_STAGES_LOG2, ML = G_STAGE_DEPTH_LOG2)
wr_data  in  G_TAP_WIDTH  coefficient
wr_en  in  1  write strobe
wr_err  out  1  one-cycle pulse: write was dropped
load_bank  in  G_NUM_BANKS_LOG2  bank to program into the FIR
load_valid  in  1  load request
load_ready  out  1  request accepted when load_valid && load_ready
active_bank  out  G_NUM_BANKS_LOG2  bank currently in the FIR
loaded  out  1  FIR holds a complete bank and is running
fir_enable  out  1  drives FIR enable
fir_tap_dout / fir_tap_valid / fir_tap_ready  out/out/in  G_TAP_WIDTH/1/1  FIR tap stream
s_din / s_valid / s_ready  in/in/out  G_DATA_WIDTH/1/1  upstream samples
fir_din / fir_din_valid / fir_din_ready  out/out/in  G_DATA_WIDTH/1/1  to FIR
fir_dout_valid / fir_dout_ready  in/in  1/1  monitored FIR output handshake

Behaviour:
- Constant T = 2**(NL+ML). Tap memory is NB*T entries with a synchronous 1-cycle read.
- Reset values:
  - state S_IDLE
  - fir_enable=0, fir_tap_valid=0, s_ready=0, fir_din_valid=0
  - load_ready=1, loaded=0, active_bank=0, wr_err=0, inflight=0
- Memory contents are not reset.
- States:
  - S_IDLE: unconfigured, load_ready=1. On load accept, capture the bank and go to S_DRAIN.
  - S_RUN: loaded=1, load_ready=1, fir_din=s_din, fir_din_valid=s_valid, s_ready=fir_din_ready (combinational passthrough).
    - On load accept: set loaded=0, gate s_ready/fir_din_valid to 0 from the next cycle, go to S_DRAIN.
    - If a load is accepted in the same cycle as a sample handshake, the sample counts as in flight.
  - S_DRAIN: load_ready=0. Wait until inflight==0, then fir_enable<=0 and go to S_DISABLE.
    - inflight is set on a fir_din handshake and cleared on a fir_dout handshake.
  - S_DISABLE: hold fir_enable=0 for exactly 2 cycles, prefetch tap 0, then fir_enable<=1 and go to S_STREAM.
  - S_STREAM: present taps 0..T-1 of the captured bank in index order.
    - fir_tap_dout/valid are registered and held stable until fir_tap_ready.
    - Next tap is fetched on handshake (prefetch keeps 1 tap/cycle throughput).
    - After the T-th handshake: fir_tap_valid<=0, active_bank<=captured bank, loaded<=1, go to S_RUN.
- Host writes:
  - Accepted in any state, with one exception: a write to the captured bank during S_DRAIN/S_DISABLE/S_STREAM is dropped and wr_err pulses 1 cycle later.
  - A write to active_bank during S_RUN updates memory only; the FIR is unchanged until the next load.
- load_valid while load_ready=0 is ignored (not queued).
- Reloading the same bank as active_bank performs the full sequence.
- Reset mid-stream returns to S_IDLE with fir_enable=0. The FIR is reinitialised on the next load.

Optional Feature:
FIR_TAP_SEQ_CHECKSUM_EN:
- Defined: adds output tap_checksum[31:0], the wrapping sum of sign-extended taps streamed in the last completed load.
  - Cleared at S_DISABLE entry.
  - Updated on each tap handshake.
  - Reset value 0.
- Undefined: port and logic are absent.

Decomposition:
- Package fir_tap_seq_pkg holds: state_t enum (S_IDLE, S_DRAIN, S_DISABLE, S_STREAM, S_RUN), the T and bank-address-width helper constants, and the checksum width constant.
- One sub-module, fir_tap_seq_ram: simple dual-port, sync read, NB*T x G_TAP_WIDTH.

Test Plan:
All scenarios use defaults (T=16, NB=4).
- Write bank 1 taps = index+1, load bank 1 with fir_tap_ready=1 → fir_enable low exactly 2 cycles; taps 1..16 on 16 consecutive cycles; loaded=1, active_bank=1. With FIR_TAP_SEQ_CHECKSUM_EN, checksum=136.
- Random fir_tap_ready backpressure (50%) → fir_tap_dout stable while valid && !ready; exactly 16 handshakes, in order.
- Sample accepted, then load requested before the FIR output; hold fir_dout_ready=0 for 10 cycles → fir_enable stays 1 until the fir_dout handshake, then drops.
- Write to bank 2 while loading bank 2 → wr_err pulse; memory unchanged. Write to bank 3 in the same window → stored, no wr_err.
- Assert reset at tap 7 of streaming → next cycle fir_enable=0, fir_tap_valid=0, loaded=0; a subsequent load streams all 16 taps.
- load_valid during S_STREAM → ignored; state returns to S_RUN with the original captured bank.

Source files
------------

// File: rtl/fir_tap_seq_pkg.sv
// fir_tap_seq_pkg: shared state encoding and sizing helpers for fir_tap_sequencer.
package fir_tap_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_DISABLE, S_STREAM, S_RUN} state_t;
   localparam int CHECKSUM_W = 32;
   function automatic int tap_count(input int nl, input int ml);
      return 2 ** (nl + ml);
   endfunction
   function automatic int bank_addr_w(input int bl, input int nl, input int ml);
      return bl + nl + ml;
   endfunction
endpackage

// File: rtl/fir_tap_seq_ram.sv
// fir_tap_seq_ram: simple dual-port coefficient store with a 1-cycle synchronous read.
module fir_tap_seq_ram #(
   parameter int AW = 6,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem_q [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      rdata <= mem_q[raddr];
   end
endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: banked coefficient store that drains, disables and reprograms a configurable_fir.
// Define FIR_TAP_SEQ_CHECKSUM_EN to add the tap_checksum output.
module fir_tap_sequencer
   import fir_tap_seq_pkg::*;
#(
   parameter int G_NUM_STAGES_LOG2  = 2,
   parameter int G_STAGE_DEPTH_LOG2 = 2,
   parameter int G_TAP_WIDTH        = 16,
   parameter int G_DATA_WIDTH       = 16,
   parameter int G_NUM_BANKS_LOG2   = 2
) (
   input  logic                                          clk,
   input  logic                                          reset,
`ifdef FIR_TAP_SEQ_CHECKSUM_EN
   output logic [CHECKSUM_W-1:0]                         tap_checksum,
`endif
   input  logic [G_NUM_BANKS_LOG2-1:0]                   wr_bank,
   input  logic [G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2-1:0] wr_addr,
   input  logic [G_TAP_WIDTH-1:0]                        wr_data,
   input  logic                                          wr_en,
   output logic                                          wr_err,
   input  logic [G_NUM_BANKS_LOG2-1:0]                   load_bank,
   input  logic                                          load_valid,
   output logic                                          load_ready,
   output logic [G_NUM_BANKS_LOG2-1:0]                   active_bank,
   output logic                                          loaded,
   output logic                                          fir_enable,
   output logic [G_TAP_WIDTH-1:0]                        fir_tap_dout,
   output logic                                          fir_tap_valid,
   input  logic                                          fir_tap_ready,
   input  logic [G_DATA_WIDTH-1:0]                       s_din,
   input  logic                                          s_valid,
   output logic                                          s_ready,
   output logic [G_DATA_WIDTH-1:0]                       fir_din,
   output logic                                          fir_din_valid,
   input  logic                                          fir_din_ready,
   input  logic                                          fir_dout_valid,
   input  logic                                          fir_dout_ready
);
   localparam int TL = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
   localparam int T  = tap_count(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
   localparam int AW = bank_addr_w(G_NUM_BANKS_LOG2, G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
   localparam logic [TL-1:0] LAST = TL'(T - 1);

   state_t                      state_q, state_d;
   logic                        fir_enable_q, fir_enable_d;
   logic                        fir_tap_valid_q, fir_tap_valid_d;
   logic                        loaded_q, loaded_d;
   logic                        wr_err_q, wr_err_d;
   logic                        inflight_q, inflight_d;
   logic                        dis_q, dis_d;
   logic [G_TAP_WIDTH-1:0]      fir_tap_dout_q, fir_tap_dout_d;
   logic [G_NUM_BANKS_LOG2-1:0] bank_q, bank_d;
   logic [G_NUM_BANKS_LOG2-1:0] active_bank_q, active_bank_d;
   logic [TL-1:0]               idx_q, idx_d;
   logic [TL-1:0]               rd_idx;
   logic [G_TAP_WIDTH-1:0]      ram_rdata;
   logic                        load_acc, din_hs, dout_hs, tap_hs, ram_we;

   assign fir_enable    = fir_enable_q;
   assign fir_tap_valid = fir_tap_valid_q;
   assign fir_tap_dout  = fir_tap_dout_q;
   assign loaded        = loaded_q;
   assign wr_err        = wr_err_q;
   assign active_bank   = active_bank_q;

   fir_tap_seq_ram #(.AW(AW), .DW(G_TAP_WIDTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr ({wr_bank, wr_addr}),
      .wdata (wr_data),
      .raddr ({bank_q, rd_idx}),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d         = state_q;
      fir_enable_d    = fir_enable_q;
      fir_tap_valid_d = fir_tap_valid_q;
      fir_tap_dout_d  = fir_tap_dout_q;
      loaded_d        = loaded_q;
      bank_d          = bank_q;
      active_bank_d   = active_bank_q;
      idx_d           = idx_q;
      dis_d           = dis_q;
      load_ready      = state_q == S_IDLE || state_q == S_RUN;
      load_acc        = load_valid && load_ready;
      fir_din         = s_din;
      fir_din_valid   = state_q == S_RUN ? s_valid : 1'b0;
      s_ready         = state_q == S_RUN ? fir_din_ready : 1'b0;
      din_hs          = fir_din_valid && fir_din_ready;
      dout_hs         = fir_dout_valid && fir_dout_ready;
      tap_hs          = fir_tap_valid_q && fir_tap_ready;
      wr_err_d        = wr_en && !load_ready && wr_bank == bank_q;
      ram_we          = wr_en && !wr_err_d;
      inflight_d      = din_hs ? 1'b1 : dout_hs ? 1'b0 : inflight_q;
      // Read address runs one tap ahead of the presented tap, two when it is consumed this cycle.
      rd_idx          = state_q == S_STREAM ? idx_q + (tap_hs ? TL'(2) : TL'(1)) : TL'(dis_q);
      case (state_q)
         S_IDLE, S_RUN: if (load_acc) begin
            bank_d   = load_bank;
            loaded_d = 1'b0;
            state_d  = S_DRAIN;
         end
         S_DRAIN: begin
            dis_d = 1'b0;
            if (!inflight_q) begin
               fir_enable_d = 1'b0;
               state_d      = S_DISABLE;
            end
         end
         S_DISABLE: begin
            dis_d = 1'b1;
            if (dis_q) begin
               fir_enable_d    = 1'b1;
               fir_tap_valid_d = 1'b1;
               fir_tap_dout_d  = ram_rdata;
               idx_d           = '0;
               state_d         = S_STREAM;
            end
         end
         S_STREAM: if (tap_hs) begin
            idx_d          = idx_q + TL'(1);
            fir_tap_dout_d = ram_rdata;
            if (idx_q == LAST) begin
               fir_tap_valid_d = 1'b0;
               active_bank_d   = bank_q;
               loaded_d        = 1'b1;
               state_d         = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         fir_enable_q    <= 1'b0;
         fir_tap_valid_q <= 1'b0;
         fir_tap_dout_q  <= '0;
         loaded_q        <= 1'b0;
         wr_err_q        <= 1'b0;
         inflight_q      <= 1'b0;
         dis_q           <= 1'b0;
         bank_q          <= '0;
         active_bank_q   <= '0;
         idx_q           <= '0;
      end else begin
         state_q         <= state_d;
         fir_enable_q    <= fir_enable_d;
         fir_tap_valid_q <= fir_tap_valid_d;
         fir_tap_dout_q  <= fir_tap_dout_d;
         loaded_q        <= loaded_d;
         wr_err_q        <= wr_err_d;
         inflight_q      <= inflight_d;
         dis_q           <= dis_d;
         bank_q          <= bank_d;
         active_bank_q   <= active_bank_d;
         idx_q           <= idx_d;
      end
   end

`ifdef FIR_TAP_SEQ_CHECKSUM_EN
   logic [CHECKSUM_W-1:0] sum_q, sum_d;
   always_comb begin
      sum_d = (state_q == S_DRAIN && !inflight_q) ? '0
            : tap_hs ? sum_q + CHECKSUM_W'($signed(fir_tap_dout_q)) : sum_q;
   end
   always_ff @(posedge clk) begin
      if (reset) sum_q <= '0;
      else sum_q <= sum_d;
   end
   assign tap_checksum = sum_q;
`endif
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: directed scenarios checked against a bank/tap-level model of the sequencer.
module tb_fir_tap_sequencer;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  wr_bank = '0;
   logic [3:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        wr_en = 1'b0;
   logic        wr_err;
   logic [1:0]  load_bank = '0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [1:0]  active_bank;
   logic        loaded, fir_enable;
   logic [15:0] fir_tap_dout;
   logic        fir_tap_valid;
   logic        fir_tap_ready = 1'b1;
   logic [15:0] s_din = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] fir_din;
   logic        fir_din_valid;
   logic        fir_din_ready = 1'b1;
   logic        fir_dout_valid = 1'b0;
   logic        fir_dout_ready = 1'b0;
`ifdef FIR_TAP_SEQ_CHECKSUM_EN
   logic [31:0] tap_checksum;
`endif

   always #5 clk = ~clk;

   fir_tap_sequencer dut (
      .clk            (clk),
      .reset          (reset),
`ifdef FIR_TAP_SEQ_CHECKSUM_EN
      .tap_checksum   (tap_checksum),
`endif
      .wr_bank        (wr_bank),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_en          (wr_en),
      .wr_err         (wr_err),
      .load_bank      (load_bank),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .active_bank    (active_bank),
      .loaded         (loaded),
      .fir_enable     (fir_enable),
      .fir_tap_dout   (fir_tap_dout),
      .fir_tap_valid  (fir_tap_valid),
      .fir_tap_ready  (fir_tap_ready),
      .s_din          (s_din),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .fir_din        (fir_din),
      .fir_din_valid  (fir_din_valid),
      .fir_din_ready  (fir_din_ready),
      .fir_dout_valid (fir_dout_valid),
      .fir_dout_ready (fir_dout_ready)
   );

   int checks = 0;
   int errors = 0;
   int hs_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a load window opens on an accepted request and closes after T taps of the captured bank.
   logic [15:0] mem_m [4][T];
   logic        busy_m = 1'b0, loaded_m = 1'b0, err_m = 1'b0, stall_m = 1'b0;
   logic [1:0]  cap_m = '0, active_m = '0;
   logic [15:0] prev_dout = '0;
   int          cnt_m = 0;

   always @(negedge clk) begin
      if (!reset) begin
         chk("load_ready", load_ready, !busy_m);
         chk("loaded", loaded, loaded_m);
         chk("active_bank", active_bank, active_m);
         chk("wr_err", wr_err, err_m);
         chk("s_ready", s_ready, loaded_m ? fir_din_ready : 1'b0);
         chk("fir_din_valid", fir_din_valid, loaded_m ? s_valid : 1'b0);
         if (loaded_m) chk("fir_din", fir_din, s_din);
         if (loaded_m) chk("fir_enable_run", fir_enable, 1'b1);
         if (!busy_m) chk("tap_valid_idle", fir_tap_valid, 1'b0);
         if (stall_m) begin
            chk("tap_valid_hold", fir_tap_valid, 1'b1);
            chk("tap_dout_hold", fir_tap_dout, prev_dout);
         end
         if (fir_tap_valid && fir_tap_ready && busy_m) begin
            chk("tap_value", fir_tap_dout, mem_m[cap_m][cnt_m]);
            chk("fir_enable_stream", fir_enable, 1'b1);
         end
      end
      if (reset) begin
         busy_m = 1'b0; loaded_m = 1'b0; err_m = 1'b0; stall_m = 1'b0;
         active_m = '0; cnt_m = 0;
      end else begin
         err_m = wr_en && busy_m && wr_bank == cap_m;
         if (wr_en && !err_m) mem_m[wr_bank][wr_addr] = wr_data;
         stall_m = fir_tap_valid && !fir_tap_ready;
         prev_dout = fir_tap_dout;
         if (busy_m) begin
            if (fir_tap_valid && fir_tap_ready) begin
               cnt_m++;
               hs_total++;
               if (cnt_m == T) begin
                  busy_m = 1'b0; loaded_m = 1'b1; active_m = cap_m;
               end
            end
         end else if (load_valid) begin
            busy_m = 1'b1; loaded_m = 1'b0; cap_m = load_bank; cnt_m = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
      wr_bank = b; wr_addr = a; wr_data = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic load(input logic [1:0] b);
      load_bank = b; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic wait_loaded(input int budget);
      int n = 0;
      while (!loaded && n < budget) begin
         tick();
         n++;
      end
      chk("load_done", loaded, 1'b1);
   endtask

   initial begin
      int h0, low, vcyc, hi, n;
      logic [15:0] first, last;
      logic got_first;
      for (int b = 0; b < 4; b++) for (int i = 0; i < T; i++) mem_m[b][i] = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_fir_enable", fir_enable, 1'b0);
      chk("rst_tap_valid", fir_tap_valid, 1'b0);
      chk("rst_load_ready", load_ready, 1'b1);
      chk("rst_loaded", loaded, 1'b0);
      chk("rst_active_bank", active_bank, 2'd0);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_wr_err", wr_err, 1'b0);
      for (int i = 0; i < T; i++) begin
         write(2'd0, 4'(i), 16'h0A00 + 16'(i));
         write(2'd1, 4'(i), 16'(i + 1));
         write(2'd2, 4'(i), 16'hFFFF - 16'(i));
         write(2'd3, 4'(i), 16'h3000 + 16'(i));
      end
      load(2'd0);
      wait_loaded(100);
      chk("bank0_active", active_bank, 2'd0);

      // Reprogram from a running FIR with no backpressure.
      h0 = hs_total; low = 0; vcyc = 0; got_first = 1'b0; first = '0; last = '0;
      load(2'd1);
      for (int c = 0; c < 60 && !loaded; c++) begin
         if (!fir_enable) low++;
         if (fir_tap_valid) begin
            if (!got_first) first = fir_tap_dout;
            got_first = 1'b1;
            last = fir_tap_dout;
            vcyc++;
         end
         tick();
      end
      chk("enable_low_cycles", low, 2);
      chk("tap_valid_cycles", vcyc, 16);
      chk("tap_handshakes", hs_total - h0, 16);
      chk("first_tap", first, 16'd1);
      chk("last_tap", last, 16'd16);
      chk("s1_loaded", loaded, 1'b1);
      chk("s1_active", active_bank, 2'd1);
`ifdef FIR_TAP_SEQ_CHECKSUM_EN
      chk("checksum_bank1", tap_checksum, 32'd136);
`endif

      // Random backpressure on the tap stream.
      h0 = hs_total;
      load(2'd3);
      for (int c = 0; c < 300 && !loaded; c++) begin
         fir_tap_ready = 1'($urandom_range(0, 1));
         tick();
      end
      fir_tap_ready = 1'b1;
      chk("bp_handshakes", hs_total - h0, 16);
      chk("bp_active", active_bank, 2'd3);

      // Sample in flight holds the FIR enabled until its output handshake.
      s_din = 16'h1234; s_valid = 1'b1;
      tick();
      s_valid = 1'b0; fir_dout_valid = 1'b1; fir_dout_ready = 1'b0;
      load(2'd1);
      hi = 0;
      for (int c = 0; c < 10; c++) begin
         if (fir_enable) hi++;
         tick();
      end
      chk("drain_enable_held", hi, 10);
      fir_dout_ready = 1'b1;
      tick();
      fir_dout_ready = 1'b0; fir_dout_valid = 1'b0;
      chk("drain_enable_at_hs", fir_enable, 1'b1);
      n = 0;
      while (fir_enable && n < 4) begin
         tick();
         n++;
      end
      chk("drain_enable_drop", fir_enable, 1'b0);
      wait_loaded(100);

      // Writes during a load: captured bank is protected, others are stored.
      fir_tap_ready = 1'b0;
      load(2'd2);
      write(2'd2, 4'd5, 16'h1234);
      chk("wr_err_captured", wr_err, 1'b1);
      write(2'd3, 4'd5, 16'h5555);
      chk("wr_err_other", wr_err, 1'b0);
      fir_tap_ready = 1'b1;
      wait_loaded(100);
      chk("s4_active", active_bank, 2'd2);
`ifdef FIR_TAP_SEQ_CHECKSUM_EN
      chk("checksum_bank2", tap_checksum, 32'hFFFF_FF78);
`endif

      // Load request while streaming is ignored.
      fir_tap_ready = 1'b0;
      load(2'd3);
      repeat (6) tick();
      chk("stream_stalled", fir_tap_valid, 1'b1);
      load(2'd0);
      fir_tap_ready = 1'b1;
      wait_loaded(100);
      chk("ignore_active", active_bank, 2'd3);
      repeat (3) tick();
      chk("ignore_still_loaded", loaded, 1'b1);
      chk("ignore_load_ready", load_ready, 1'b1);

      // Reset mid-stream, then a full reload.
      h0 = hs_total;
      load(2'd1);
      n = 0;
      while (hs_total - h0 < 7 && n < 100) begin
         tick();
         n++;
      end
      chk("reached_tap7", hs_total - h0, 7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_enable", fir_enable, 1'b0);
      chk("rst_mid_valid", fir_tap_valid, 1'b0);
      chk("rst_mid_loaded", loaded, 1'b0);
      h0 = hs_total;
      load(2'd1);
      wait_loaded(100);
      chk("reload_handshakes", hs_total - h0, 16);
      chk("reload_active", active_bank, 2'd1);
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
